// File: rtl/cmd_responder_if.sv
// Card-side command/response handshake bundle for cmd_responder.
//   slave  : the responder itself (reports commands, takes response decisions)
//   master : card logic / bench (consumes commands, supplies response decisions)
// Signals:
//   ocmd_valid  1-cycle pulse, good command captured
//   ocmd_index  received command index (held)
//   ocmd_arg    received command argument (held)
//   ocrc_err    1-cycle pulse, frame rejected
//   obusy       high while a command/response is in progress
//   odone       1-cycle pulse after the response end bit
//   iresp_send  transmit a response carrying iresp_arg
//   iresp_skip  drop the response
//   iresp_arg   response status field
interface cmd_responder_if;
  logic        ocmd_valid;
  logic [5:0]  ocmd_index;
  logic [31:0] ocmd_arg;
  logic        ocrc_err;
  logic        obusy;
  logic        odone;
  logic        iresp_send;
  logic        iresp_skip;
  logic [31:0] iresp_arg;

  modport slave (
    output ocmd_valid, ocmd_index, ocmd_arg, ocrc_err, obusy, odone,
    input  iresp_send, iresp_skip, iresp_arg
  );

  modport master (
    input  ocmd_valid, ocmd_index, ocmd_arg, ocrc_err, obusy, odone,
    output iresp_send, iresp_skip, iresp_arg
  );
endinterface

// File: rtl/cmd_responder.sv
// SD CMD line responder (card side): receives 48-bit host command frames,
// checks framing and CRC7, reports index/argument, then answers with an
// R1-format 48-bit response on the same line.
// Ports:
//   iclk      clock, everything happens on the rising edge
//   irst      asynchronous active-high reset
//   iocmd_sd  bidirectional CMD line; high-Z unless transmitting (pulled up)
//   bus       cmd_responder_if.slave, command report / response decision
// Parameters:
//   NCR       minimum periods from command end bit to response start bit
//   WAIT_MAX  periods after the end bit to wait for a response decision
module cmd_responder #(
  parameter int unsigned NCR      = 2,
  parameter int unsigned WAIT_MAX = 64
) (
  input  logic           iclk,
  input  logic           irst,
  inout  wire            iocmd_sd,
  cmd_responder_if.slave bus
);

  localparam int unsigned FRAME_W = 48;
  localparam int unsigned DATA_W  = 40;
  localparam int unsigned CRC_W   = 7;
  localparam int unsigned RX_W    = FRAME_W - 1;
  localparam int unsigned BCNT_W  = 6;
  localparam int unsigned CNT_W   = $clog2(WAIT_MAX + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT,
    S_TX
  } state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [RX_W-1:0]     rx_q, rx_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                armed_q, armed_d;
  logic [31:0]         rsp_arg_q, rsp_arg_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [BCNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic                oe_q, oe_d;
  logic [5:0]          idx_q, idx_d;
  logic [31:0]         arg_q, arg_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                line_c;
  logic [DATA_W-1:0]   cmd_data_c;
  logic                frame_ok_c;
  logic                arm_c;
  logic [DATA_W-1:0]   rsp_data_c;
  logic [FRAME_W-1:0]  rsp_frame_c;

  // Serial CRC7 (x^7 + x^3 + 1, zero seed) over a 40-bit message, MSB first;
  // shared by the receive check and the response generator.
  function automatic logic [CRC_W-1:0] crc7(input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = data[i] ^ crc[CRC_W-1];
      crc = {crc[CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  // Line drive: released whenever the transmitter is idle.
  assign iocmd_sd = oe_q ? tx_q[FRAME_W-1] : 1'bz;
  assign line_c   = iocmd_sd;

  // rx_q after 47 shifts: [46] transmission, [45:40] index, [39:8] arg,
  // [7:1] CRC, [0] end. The start bit is always 0.
  assign cmd_data_c = {1'b0, rx_q[RX_W-1:8]};
  assign frame_ok_c = rx_q[RX_W-1] && rx_q[0] && (crc7(cmd_data_c) == rx_q[7:1]);

  // A send request in the current WAIT cycle counts as armed immediately so
  // the start bit can land exactly NCR periods after the end bit.
  assign arm_c       = armed_q || (bus.iresp_send && !bus.iresp_skip);
  assign rsp_data_c  = {2'b00, idx_q, (armed_q ? rsp_arg_q : bus.iresp_arg)};
  assign rsp_frame_c = {rsp_data_c, crc7(rsp_data_c), 1'b1};

  // State and datapath registers.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_q       <= '0;
      wait_cnt_q <= '0;
      armed_q    <= 1'b0;
      rsp_arg_q  <= '0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      oe_q       <= 1'b0;
      idx_q      <= '0;
      arg_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_q       <= rx_d;
      wait_cnt_q <= wait_cnt_d;
      armed_q    <= armed_d;
      rsp_arg_q  <= rsp_arg_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      oe_q       <= oe_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_d       = rx_q;
    wait_cnt_d = wait_cnt_q;
    armed_d    = armed_q;
    rsp_arg_d  = rsp_arg_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    oe_d       = oe_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    done_d     = 1'b0;

    // Post-end-bit period counter, saturating at WAIT_MAX.
    if ((state_q == S_CHECK || state_q == S_WAIT) &&
        (wait_cnt_q < CNT_W'(WAIT_MAX))) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (line_c == 1'b0) begin
          state_d  = S_RX;
          rx_cnt_d = '0;
        end
      end

      S_RX: begin
        rx_d = {rx_q[RX_W-2:0], line_c};
        if (rx_cnt_q == BCNT_W'(RX_W - 1)) begin
          state_d    = S_CHECK;
          wait_cnt_d = CNT_W'(1);
        end else begin
          rx_cnt_d = rx_cnt_q + BCNT_W'(1);
        end
      end

      S_CHECK: begin
        armed_d = 1'b0;
        if (frame_ok_c) begin
          idx_d   = rx_q[45:40];
          arg_d   = rx_q[39:8];
          valid_d = 1'b1;
          state_d = S_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (bus.iresp_skip) begin
          armed_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (bus.iresp_send && !armed_q) begin
            armed_d   = 1'b1;
            rsp_arg_d = bus.iresp_arg;
          end
          if (arm_c && (wait_cnt_q >= CNT_W'(NCR))) begin
            armed_d  = 1'b0;
            tx_d     = rsp_frame_c;
            tx_cnt_d = '0;
            oe_d     = 1'b1;
            state_d  = S_TX;
          end else if (!arm_c && (wait_cnt_q >= CNT_W'(WAIT_MAX))) begin
            state_d = S_IDLE;
          end
        end
      end

      S_TX: begin
        if (tx_cnt_q == BCNT_W'(FRAME_W - 1)) begin
          oe_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tx_d     = {tx_q[FRAME_W-2:0], 1'b0};
          tx_cnt_d = tx_cnt_q + BCNT_W'(1);
        end
      end

      default: begin
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.ocmd_valid = valid_q;
  assign bus.ocmd_index = idx_q;
  assign bus.ocmd_arg   = arg_q;
  assign bus.ocrc_err   = err_q;
  assign bus.obusy      = busy_q;
  assign bus.odone      = done_q;

endmodule

// File: doc/cmd_responder.md
Name: cmd_responder

Overview:
- Card-side end of the SD CMD line: receives 48-bit host command frames, checks framing and CRC7, reports index/argument to card logic, then transmits a 48-bit R1-format response on the same line.
- Counterpart of cmd_driver; used as an SD card model in benches and as the basis of card-emulation logic.
- Single bidirectional line; released (high-Z) whenever not transmitting. The external pull-up holds idle high.

Parameters:
- NCR, 2, minimum clock periods between sampling the command end bit and driving the response start bit (legal 2..63).
- WAIT_MAX, 64, clock periods after the end bit within which a response decision must arrive; otherwise the command is dropped.

Ports:
- iclk  input  1  clock; all sampling and driving on the rising edge
- irst  input  1  reset; asynchronous, active-high
- iocmd_sd  inout  1  SD CMD line
- ocmd_valid  output  1  one-cycle pulse: good command captured
- ocmd_index  output  6  received command index; held until next good command
- ocmd_arg  output  32  received argument; held until next good command
- ocrc_err  output  1  one-cycle pulse: frame rejected
- iresp_send  input  1  transmit response (sampled only in WAIT)
- iresp_skip  input  1  send no response (sampled only in WAIT)
- iresp_arg  input  32  response status field; latched with iresp_send
- obusy  output  1  high from start-bit detection until return to IDLE
- odone  output  1  one-cycle pulse after the response end bit has been driven

Behaviour:
- Reset (asynchronous, any state): state IDLE, line released immediately (including mid-transmission), all outputs 0, ocmd_index/ocmd_arg cleared.
- Command frame, MSB first: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
- CRC7: polynomial x^7+x^3+1, register initialised to 0, computed over the first 40 bits (start through arg). The same generator serves RX checking and TX generation.
- IDLE: line sampled every cycle; a 0 moves to RX, and obusy rises on the next edge.
- RX: shifts the remaining 47 bits (6-bit counter). After the end bit is sampled, moves to CHECK.
- CHECK (1 cycle):
  - Valid frame requires transmission bit = 1, CRC match and end bit = 1.
  - Valid: update ocmd_index/ocmd_arg, pulse ocmd_valid, go to WAIT.
  - Invalid: pulse ocrc_err, go to IDLE, no response.
- WAIT:
  - Cycle counter runs from the end-bit edge.
  - iresp_skip goes to IDLE. If iresp_send and iresp_skip are asserted in the same cycle, skip wins.
  - iresp_send latches iresp_arg and arms transmission.
  - TX starts on the first edge at which armed is true and counter ≥ NCR. The start bit therefore appears no earlier than NCR periods after the end bit.
  - Counter reaching WAIT_MAX unarmed sends the block to IDLE silently.
- TX: drives 48 bits, one per clock:
  - start 0, transmission 0
  - echoed ocmd_index
  - latched arg
  - CRC7 over the first 40 response bits
  - end 1
  Line is released on the edge after the end bit; odone pulses in that cycle; then IDLE.
- The line is never driven outside TX; only 0/1 are driven, never X.
- Line activity in CHECK/WAIT/TX is ignored (no collision detection). iresp_send/iresp_skip outside WAIT are ignored.
- obusy falls on the same edge that enters IDLE.

Test Plan:
- Host sends CMD17, arg 0x00000000, CRC 0x2A (0101010) → ocmd_valid pulse one cycle after end bit, ocmd_index=17, ocmd_arg=0; no ocrc_err.
- Then iresp_send with iresp_arg=0x00000900 → line carries 0,0,010001,0x00000900,0110011,1 starting exactly NCR periods after end bit, released after the end bit, odone pulses.
- CMD0, arg 0, CRC 0x4A → ocmd_valid, index 0. Then iresp_skip and iresp_send in the same cycle → no drive, line stays Z, back to IDLE.
- CMD17 with one CRC bit flipped → ocrc_err pulse, no ocmd_valid, ocmd_index unchanged, line never driven. Repeat with end bit 0 and with transmission bit 0 → same result.
- Valid command, no decision for WAIT_MAX cycles → IDLE, obusy low. A following valid command is accepted normally.
- Reset asserted at response bit 20 → line Z within the same time step, outputs 0. After release, a new CMD17 is accepted and answered correctly.
